multicycle_control_fsm: RTL and testbench
=========================================

// Module: multicycle_control_fsm
// PURPOSE
//   Main sequencer for the multi-cycle RV32I core. It steps each instruction through
//   FETCH/DECODE/EXECUTE/MEM/WRITEBACK and drives every datapath strobe and mux select.
//   It resolves branches (signed and unsigned) and owns the program_counter update.
//   The PC, IR, ALU, regfile and memory port are external; this block only steers them.
// PARAMETERS
//   MAX_WAIT  255  cycles a memory request may wait for mem_ready before entering TRAP
// PORTS
//   clk          in   1   core clock; all state updates on posedge
//   rst_n        in   1   synchronous reset, active low
//   opcode       in   7   IR[6:0]; valid from DECODE onward
//   func3        in   3   IR[14:12]; valid from DECODE onward
//   rs1v         in   32  regfile read port 1 value
//   rs2v         in   32  regfile read port 2 value
//   mem_ready    in   1   memory completes the current request this cycle
//   mem_req      out  1   memory request active
//   mem_we       out  1   request is a store
//   mem_addr_sel out  1   0 = PC, 1 = registered ALU result
//   ir_we        out  1   load fetched word into IR
//   pc_we        out  1   update PC
//   pc_sel       out  1   0 = PC+4, 1 = ALU result
//   alu_a_sel    out  2   00 = rs1v, 01 = PC, 10 = zero
//   alu_b_sel    out  1   0 = rs2v, 1 = immediate
//   rf_we        out  1   regfile write enable
//   wb_sel       out  2   00 = ALU, 01 = memory data, 10 = PC+4
//   state_o      out  3   current state (debug)
//   trap         out  1   sticky illegal-instruction or memory-timeout flag
//   instr_retired out 1   one-cycle pulse when the instruction commits (same cycle as pc_we)
// BEHAVIOUR
//   - Clock and reset: one clock. Reset is synchronous and active-low. When rst_n=0 at a
//     posedge: state <= FETCH, wait counter <= 0, trap <= 0. All outputs are forced to 0
//     while rst_n=0. Reset mid-instruction abandons that instruction, with no strobe.
//   - Output decode: outputs are combinational from state, opcode/func3 and mem_ready.
//     Any select not listed below is 0.
//   - FETCH: mem_req=1, mem_addr_sel=0.
//     On mem_ready: ir_we=1, next state DECODE. Otherwise stay in FETCH.
//   - DECODE: one cycle. Legal opcodes go to EXECUTE:
//       0110011 R, 0010011 I-ALU, 0000011 LOAD, 0100011 STORE, 1100011 BRANCH,
//       1101111 JAL, 1100111 JALR, 0110111 LUI, 0010111 AUIPC.
//     Any other opcode goes to TRAP.
//   - EXECUTE, per opcode class:
//       R:      a=rs1, b=rs2, then WRITEBACK.
//       I-ALU:  a=rs1, b=imm, then WRITEBACK.
//       LUI:    a=zero, b=imm, then WRITEBACK.
//       AUIPC:  a=PC, b=imm, then WRITEBACK.
//       LOAD/STORE: a=rs1, b=imm, then MEM.
//       JAL:    a=PC, b=imm; rf_we=1, wb_sel=10, pc_we=1, pc_sel=1, retire, then FETCH.
//       JALR:   same as JAL but a=rs1.
//       BRANCH: a=PC, b=imm; pc_we=1, pc_sel=taken, retire, then FETCH.
//   - Branch compare, selected by func3:
//       000 eq, 001 ne, 100 lt signed, 101 ge signed, 110 lt unsigned, 111 ge unsigned.
//       func3 010 or 011 goes to TRAP, with no pc_we and no retire.
//   - MEM: mem_req=1, mem_addr_sel=1, mem_we=1 for STORE. Wait for mem_ready.
//       LOAD, on mem_ready: go to WRITEBACK.
//       STORE, on mem_ready: pc_we=1, pc_sel=0, retire, then FETCH.
//   - WRITEBACK: rf_we=1, pc_we=1, pc_sel=0, retire, then FETCH.
//       wb_sel=01 for LOAD, otherwise 00.
//   - Wait counter: counts consecutive cycles in FETCH or MEM with mem_ready=0, and
//     clears on state change. When it reaches MAX_WAIT with mem_ready still 0, go to TRAP.
//     If mem_ready arrives on the same cycle as the limit, the request completes normally.
//   - TRAP: sticky, trap=1, every strobe 0. Only exit is rst_n=0. mem_ready is ignored.
//   - mem_ready outside FETCH and MEM is ignored.
//   - Latency with mem_ready=1 in the first request cycle:
//       BRANCH/JAL/JALR 3 cycles, R/I/LUI/AUIPC/STORE 4 cycles, LOAD 5 cycles.
// TESTING
//   1. rst_n=0 for 2 cycles, then 1, with mem_ready=1: all outputs 0 during reset.
//      mem_req=1 in the first cycle after release. state_o sequence is FETCH,DECODE,EXEC,WB.
//   2. R-type with mem_ready=1: rf_we and pc_we assert together 4 cycles after FETCH entry.
//      instr_retired is exactly 1 cycle wide.
//   3. BLT, rs1v=32'hFFFF_FFFF, rs2v=1 -> pc_sel=1 (taken).
//      BLTU with the same values -> pc_sel=0.
//      BEQ, 5 vs 5 -> pc_sel=1.
//   4. LOAD, mem_ready held low for 3 cycles in MEM -> MEM lasts 4 cycles.
//      Then WRITEBACK with wb_sel=01; total latency 8 cycles.
//   5. opcode 7'b1111111 -> TRAP after DECODE: trap=1, pc_we never asserts.
//      rst_n=0 clears trap.
//      Branch with func3=010 -> TRAP.
//   6. MAX_WAIT=4 with mem_ready=0 in FETCH -> TRAP after 4 cycles.
//      rst_n=0 in the middle of MEM -> FETCH next cycle, with no rf_we or pc_we strobe.

Source files
------------

// File: rtl/multicycle_control_fsm.sv
// Main sequencer for the multi-cycle RV32I core: steps each instruction through
// FETCH/DECODE/EXECUTE/MEM/WRITEBACK and steers every datapath strobe and mux select.
module multicycle_control_fsm #(
  parameter int unsigned MAX_WAIT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  opcode,
  input  logic [2:0]  func3,
  input  logic [31:0] rs1v,
  input  logic [31:0] rs2v,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_addr_sel,
  output logic        ir_we,
  output logic        pc_we,
  output logic        pc_sel,
  output logic [1:0]  alu_a_sel,
  output logic        alu_b_sel,
  output logic        rf_we,
  output logic [1:0]  wb_sel,
  output logic [2:0]  state_o,
  output logic        trap,
  output logic        instr_retired
);

  localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 1);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [1:0] A_RS1  = 2'b00;
  localparam logic [1:0] A_PC   = 2'b01;
  localparam logic [1:0] A_ZERO = 2'b10;

  typedef enum logic [2:0] {
    S_FETCH   = 3'd0,
    S_DECODE  = 3'd1,
    S_EXECUTE = 3'd2,
    S_MEM     = 3'd3,
    S_WB      = 3'd4,
    S_TRAP    = 3'd5
  } state_t;

  state_t              state, state_nx;
  logic [WAIT_W-1:0]   wait_cnt, wait_nx;
  logic                timeout;
  logic                legal_op;
  logic                br_taken;
  logic                br_illegal;

  // State and wait counter; reset abandons any instruction in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_FETCH;
      wait_cnt <= '0;
    end else begin
      state    <= state_nx;
      wait_cnt <= wait_nx;
    end
  end

  assign timeout = (wait_cnt == WAIT_W'(MAX_WAIT - 1));

  always_comb begin
    legal_op = 1'b0;
    case (opcode)
      OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH,
      OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: legal_op = 1'b1;
      default:                           legal_op = 1'b0;
    endcase
  end

  // Branch resolution; func3 010/011 have no branch meaning and trap.
  always_comb begin
    br_taken   = 1'b0;
    br_illegal = 1'b0;
    case (func3)
      3'b000:  br_taken = (rs1v == rs2v);
      3'b001:  br_taken = (rs1v != rs2v);
      3'b100:  br_taken = ($signed(rs1v) <  $signed(rs2v));
      3'b101:  br_taken = ($signed(rs1v) >= $signed(rs2v));
      3'b110:  br_taken = (rs1v <  rs2v);
      3'b111:  br_taken = (rs1v >= rs2v);
      default: br_illegal = 1'b1;
    endcase
  end

  always_comb begin
    state_nx      = state;
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    mem_addr_sel  = 1'b0;
    ir_we         = 1'b0;
    pc_we         = 1'b0;
    pc_sel        = 1'b0;
    alu_a_sel     = A_RS1;
    alu_b_sel     = 1'b0;
    rf_we         = 1'b0;
    wb_sel        = 2'b00;
    trap          = 1'b0;
    instr_retired = 1'b0;

    case (state)
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_we    = 1'b1;
          state_nx = S_DECODE;
        end else if (timeout) begin
          state_nx = S_TRAP;
        end
      end
      S_DECODE: state_nx = legal_op ? S_EXECUTE : S_TRAP;
      S_EXECUTE: begin
        case (opcode)
          OP_R:  state_nx = S_WB;
          OP_I: begin
            alu_b_sel = 1'b1;
            state_nx  = S_WB;
          end
          OP_LUI: begin
            alu_a_sel = A_ZERO;
            alu_b_sel = 1'b1;
            state_nx  = S_WB;
          end
          OP_AUIPC: begin
            alu_a_sel = A_PC;
            alu_b_sel = 1'b1;
            state_nx  = S_WB;
          end
          OP_LOAD, OP_STORE: begin
            alu_b_sel = 1'b1;
            state_nx  = S_MEM;
          end
          OP_JAL, OP_JALR: begin
            alu_a_sel     = (opcode == OP_JAL) ? A_PC : A_RS1;
            alu_b_sel     = 1'b1;
            rf_we         = 1'b1;
            wb_sel        = 2'b10;
            pc_we         = 1'b1;
            pc_sel        = 1'b1;
            instr_retired = 1'b1;
            state_nx      = S_FETCH;
          end
          OP_BRANCH: begin
            alu_a_sel = A_PC;
            alu_b_sel = 1'b1;
            if (br_illegal) begin
              state_nx = S_TRAP;
            end else begin
              pc_we         = 1'b1;
              pc_sel        = br_taken;
              instr_retired = 1'b1;
              state_nx      = S_FETCH;
            end
          end
          default: state_nx = S_TRAP;
        endcase
      end
      S_MEM: begin
        mem_req      = 1'b1;
        mem_addr_sel = 1'b1;
        mem_we       = (opcode == OP_STORE);
        if (mem_ready) begin
          if (opcode == OP_STORE) begin
            pc_we         = 1'b1;
            instr_retired = 1'b1;
            state_nx      = S_FETCH;
          end else begin
            state_nx = S_WB;
          end
        end else if (timeout) begin
          state_nx = S_TRAP;
        end
      end
      S_WB: begin
        rf_we         = 1'b1;
        pc_we         = 1'b1;
        instr_retired = 1'b1;
        wb_sel        = (opcode == OP_LOAD) ? 2'b01 : 2'b00;
        state_nx      = S_FETCH;
      end
      S_TRAP:  trap = 1'b1;
      default: state_nx = S_TRAP;
    endcase

    // Reset holds every output low regardless of the state being left.
    if (!rst_n) begin
      mem_req       = 1'b0;
      mem_we        = 1'b0;
      mem_addr_sel  = 1'b0;
      ir_we         = 1'b0;
      pc_we         = 1'b0;
      pc_sel        = 1'b0;
      alu_a_sel     = 2'b00;
      alu_b_sel     = 1'b0;
      rf_we         = 1'b0;
      wb_sel        = 2'b00;
      trap          = 1'b0;
      instr_retired = 1'b0;
    end
  end

  // Counts consecutive stalled request cycles; any progress or state change clears it.
  always_comb begin
    wait_nx = '0;
    if ((state == S_FETCH || state == S_MEM) && !mem_ready && state_nx == state)
      wait_nx = wait_cnt + WAIT_W'(1);
  end

  assign state_o = rst_n ? 3'(state) : 3'd0;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed-vector bench for multicycle_control_fsm: per-cycle output vectors are
// hand-computed and compared against the packed DUT outputs.
module tb_multicycle_control_fsm;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [6:0]  opcode;
  logic [2:0]  func3;
  logic [31:0] rs1v, rs2v;
  logic        mem_ready;
  logic        mem_req, mem_we, mem_addr_sel, ir_we, pc_we, pc_sel;
  logic [1:0]  alu_a_sel;
  logic        alu_b_sel, rf_we;
  logic [1:0]  wb_sel;
  logic [2:0]  state_o;
  logic        trap, instr_retired;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  multicycle_control_fsm #(.MAX_WAIT(4)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .func3(func3),
    .rs1v(rs1v), .rs2v(rs2v), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr_sel(mem_addr_sel),
    .ir_we(ir_we), .pc_we(pc_we), .pc_sel(pc_sel),
    .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel), .rf_we(rf_we),
    .wb_sel(wb_sel), .state_o(state_o), .trap(trap),
    .instr_retired(instr_retired)
  );

  logic [16:0] obs;
  assign obs = {state_o, mem_req, mem_we, mem_addr_sel, ir_we, pc_we, pc_sel,
                alu_a_sel, alu_b_sel, rf_we, wb_sel, trap, instr_retired};

  // Fields: state, req, we, addr_sel, ir_we, pc_we, pc_sel, a_sel, b_sel, rf_we, wb_sel, trap, retired
  function automatic logic [16:0] ev(input logic [2:0] st, input logic req, we, asl, irw,
                                     pcw, pcs, input logic [1:0] a, input logic b, rfw,
                                     input logic [1:0] wb, input logic tr, ret);
    return {st, req, we, asl, irw, pcw, pcs, a, b, rfw, wb, tr, ret};
  endfunction

  task automatic check(input string tag, input logic [16:0] got, input logic [16:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%05h exp=%05h", tag, got, exp);
    end
  endtask

  // One cycle: drive mem_ready, sample mid-cycle, advance to the next negedge.
  task automatic cyc(input string tag, input logic rdy, input logic [16:0] exp);
    mem_ready = rdy;
    #1;
    check(tag, obs, exp);
    @(posedge clk);
    @(negedge clk);
  endtask

  logic [16:0] v_rst, v_f1, v_f0, v_dec, v_trap;

  task automatic fetch_decode(input string tag);
    cyc({tag, "_F"}, 1'b1, v_f1);
    cyc({tag, "_D"}, 1'b1, v_dec);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cyc("rst", 1'b1, v_rst);
    rst_n = 1'b1;
  endtask

  task automatic branch(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic taken);
    opcode = 7'b1100011; func3 = f3; rs1v = a; rs2v = b;
    fetch_decode(tag);
    cyc({tag, "_E"}, 1'b1, ev(3'd2, 0,0,0,0, 1, taken, 2'b01, 1, 0, 2'b00, 0, 1));
  endtask

  initial begin
    v_rst  = '0;
    v_f1   = ev(3'd0, 1,0,0,1, 0,0, 2'b00, 0, 0, 2'b00, 0, 0);
    v_f0   = ev(3'd0, 1,0,0,0, 0,0, 2'b00, 0, 0, 2'b00, 0, 0);
    v_dec  = ev(3'd1, 0,0,0,0, 0,0, 2'b00, 0, 0, 2'b00, 0, 0);
    v_trap = ev(3'd5, 0,0,0,0, 0,0, 2'b00, 0, 0, 2'b00, 1, 0);

    rst_n = 1'b0; mem_ready = 1'b1; opcode = 7'b0110011; func3 = 3'b000;
    rs1v = '0; rs2v = '0;
    @(negedge clk);
    cyc("rst0", 1'b1, v_rst);
    cyc("rst1", 1'b1, v_rst);
    rst_n = 1'b1;

    // R-type: writeback strobes land in the fourth cycle, then retire drops
    fetch_decode("r");
    cyc("r_E", 1'b1, ev(3'd2, 0,0,0,0, 0,0, 2'b00, 0, 0, 2'b00, 0, 0));
    cyc("r_W", 1'b1, ev(3'd4, 0,0,0,0, 1,0, 2'b00, 0, 1, 2'b00, 0, 1));

    opcode = 7'b0010011;
    fetch_decode("i");
    cyc("i_E", 1'b1, ev(3'd2, 0,0,0,0, 0,0, 2'b00, 1, 0, 2'b00, 0, 0));
    cyc("i_W", 1'b1, ev(3'd4, 0,0,0,0, 1,0, 2'b00, 0, 1, 2'b00, 0, 1));

    opcode = 7'b0110111;
    fetch_decode("lui");
    cyc("lui_E", 1'b0, ev(3'd2, 0,0,0,0, 0,0, 2'b10, 1, 0, 2'b00, 0, 0));
    cyc("lui_W", 1'b0, ev(3'd4, 0,0,0,0, 1,0, 2'b00, 0, 1, 2'b00, 0, 1));

    opcode = 7'b0010111;
    fetch_decode("auipc");
    cyc("auipc_E", 1'b1, ev(3'd2, 0,0,0,0, 0,0, 2'b01, 1, 0, 2'b00, 0, 0));
    cyc("auipc_W", 1'b1, ev(3'd4, 0,0,0,0, 1,0, 2'b00, 0, 1, 2'b00, 0, 1));

    opcode = 7'b1101111;
    fetch_decode("jal");
    cyc("jal_E", 1'b1, ev(3'd2, 0,0,0,0, 1,1, 2'b01, 1, 1, 2'b10, 0, 1));
    opcode = 7'b1100111;
    fetch_decode("jalr");
    cyc("jalr_E", 1'b1, ev(3'd2, 0,0,0,0, 1,1, 2'b00, 1, 1, 2'b10, 0, 1));

    branch("blt",  3'b100, 32'hFFFF_FFFF, 32'd1, 1'b1);
    branch("bltu", 3'b110, 32'hFFFF_FFFF, 32'd1, 1'b0);
    branch("beq",  3'b000, 32'd5, 32'd5, 1'b1);
    branch("bne",  3'b001, 32'd5, 32'd5, 1'b0);
    branch("bge",  3'b101, 32'hFFFF_FFFF, 32'd1, 1'b0);
    branch("bgeu", 3'b111, 32'hFFFF_FFFF, 32'd1, 1'b1);

    // Store with one stalled memory cycle
    opcode = 7'b0100011;
    fetch_decode("st");
    cyc("st_E",  1'b1, ev(3'd2, 0,0,0,0, 0,0, 2'b00, 1, 0, 2'b00, 0, 0));
    cyc("st_M0", 1'b0, ev(3'd3, 1,1,1,0, 0,0, 2'b00, 0, 0, 2'b00, 0, 0));
    cyc("st_M1", 1'b1, ev(3'd3, 1,1,1,0, 1,0, 2'b00, 0, 0, 2'b00, 0, 1));

    // Load with mem_ready low for 3 MEM cycles: 8-cycle instruction
    opcode = 7'b0000011;
    fetch_decode("ld");
    cyc("ld_E", 1'b1, ev(3'd2, 0,0,0,0, 0,0, 2'b00, 1, 0, 2'b00, 0, 0));
    for (int i = 0; i < 3; i++)
      cyc("ld_Mw", 1'b0, ev(3'd3, 1,0,1,0, 0,0, 2'b00, 0, 0, 2'b00, 0, 0));
    cyc("ld_M",  1'b1, ev(3'd3, 1,0,1,0, 0,0, 2'b00, 0, 0, 2'b00, 0, 0));
    cyc("ld_W",  1'b1, ev(3'd4, 0,0,0,0, 1,0, 2'b00, 0, 1, 2'b01, 0, 1));

    // mem_ready on the limit cycle completes the fetch normally
    opcode = 7'b0110011;
    for (int i = 0; i < 3; i++) cyc("lim_Fw", 1'b0, v_f0);
    cyc("lim_F", 1'b1, v_f1);
    cyc("lim_D", 1'b1, v_dec);
    cyc("lim_E", 1'b1, ev(3'd2, 0,0,0,0, 0,0, 2'b00, 0, 0, 2'b00, 0, 0));
    cyc("lim_W", 1'b1, ev(3'd4, 0,0,0,0, 1,0, 2'b00, 0, 1, 2'b00, 0, 1));

    // Illegal opcode traps after DECODE and stays there until reset
    opcode = 7'b1111111;
    fetch_decode("ill");
    cyc("ill_T0", 1'b1, v_trap);
    cyc("ill_T1", 1'b1, v_trap);
    do_reset();
    cyc("ill_F", 1'b1, v_f1);
    cyc("ill_D", 1'b1, v_dec);
    cyc("ill_T", 1'b1, v_trap);
    do_reset();

    // Branch with reserved func3
    opcode = 7'b1100011; func3 = 3'b010;
    fetch_decode("b010");
    mem_ready = 1'b1;
    #1;
    check("b010_pcwe", {16'b0, pc_we}, 17'd0);
    check("b010_ret",  {16'b0, instr_retired}, 17'd0);
    @(posedge clk);
    @(negedge clk);
    cyc("b010_T", 1'b1, v_trap);
    do_reset();

    // Fetch timeout with MAX_WAIT=4
    opcode = 7'b0110011; func3 = 3'b000;
    for (int i = 0; i < 4; i++) cyc("to_Fw", 1'b0, v_f0);
    cyc("to_T0", 1'b0, v_trap);
    cyc("to_T1", 1'b1, v_trap);
    do_reset();

    // Reset in the middle of MEM abandons the load without strobes
    opcode = 7'b0000011;
    fetch_decode("rm");
    cyc("rm_E", 1'b1, ev(3'd2, 0,0,0,0, 0,0, 2'b00, 1, 0, 2'b00, 0, 0));
    cyc("rm_M", 1'b0, ev(3'd3, 1,0,1,0, 0,0, 2'b00, 0, 0, 2'b00, 0, 0));
    rst_n = 1'b0;
    cyc("rm_rst", 1'b1, v_rst);
    rst_n = 1'b1;
    cyc("rm_F", 1'b0, v_f0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
